// File: rtl/cmpge_pattern_sequencer.sv
// Exhaustive pattern sequencer for an unsigned a >= b comparator under test:
// drives every {a,b}, samples the response, counts mismatches and records the first one.
module cmpge_pattern_sequencer #(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic [WIDTH-1:0]     pat_a,
    output logic [WIDTH-1:0]     pat_b,
    input  logic                 dut_o,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     fail_count,
    output logic [2*WIDTH-1:0]   first_fail_pat,
    output logic                 first_fail_valid
);
    localparam int              IW          = 2 * WIDTH;
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_SAMPLE,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [3:0]         settle_q, settle_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [CNT_W-1:0]   fc_q, fc_d;
    logic [IW-1:0]      ffp_q, ffp_d;
    logic               ffv_q, ffv_d;

    logic               exp_ge;
    logic               mismatch;

    assign exp_ge = (idx_q[IW-1:WIDTH] >= idx_q[WIDTH-1:0]);

    // NOTE: written as "match clears a default of 1" so an unknown response
    // takes the else path and is counted as a mismatch in simulation.
    always_comb begin
        mismatch = 1'b1;
        if (dut_o == exp_ge) mismatch = 1'b0;
    end

    // NOTE: every _d gets its hold value first, so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        fc_d     = fc_q;
        ffp_d    = ffp_q;
        ffv_d    = ffv_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d  = S_APPLY;
                    idx_d    = '0;
                    settle_d = '0;
                    busy_d   = 1'b1;
                    pass_d   = 1'b0;
                    fc_d     = '0;
                    ffp_d    = '0;
                    ffv_d    = 1'b0;
                end
            end
            S_APPLY: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            S_SAMPLE: begin
                // A mismatch seen together with abort still counts toward partial results.
                if (mismatch) begin
                    if (fc_q != CNT_MAX) fc_d = fc_q + CNT_W'(1);
                    if (!ffv_q) begin
                        ffp_d = idx_q;
                        ffv_d = 1'b1;
                    end
                end
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                end else if (idx_q == '1) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (fc_q == '0) && !mismatch;
                end else begin
                    state_d  = S_APPLY;
                    idx_d    = idx_q + IW'(1);
                    settle_d = '0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update from the same old values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fc_q     <= '0;
            ffp_q    <= '0;
            ffv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            fc_q     <= fc_d;
            ffp_q    <= ffp_d;
            ffv_q    <= ffv_d;
        end
    end

    assign pat_a            = idx_q[IW-1:WIDTH];
    assign pat_b            = idx_q[WIDTH-1:0];
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign fail_count       = fc_q;
    assign first_fail_pat   = ffp_q;
    assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_cmpge_pattern_sequencer.sv
// Bench for cmpge_pattern_sequencer: modelled comparator netlists (good, stuck-at, inverted)
// driven from a vector table, plus hand-written abort, reset and wide/saturating sequences.
module tb_cmpge_pattern_sequencer;

    typedef enum logic [1:0] {M_GOOD, M_SA1, M_SA0, M_INV} mode_e;

    typedef struct {
        mode_e      mode;
        int         abort_cyc;   // busy-cycle index at which abort is raised, -1 for none
        int         exp_busy;
        bit         exp_done;
        int         exp_fc;
        logic [1:0] exp_ffp;
        bit         exp_ffv;
        bit         exp_pass;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    // Instance 1: WIDTH=1, SETTLE=1, CNT_W=8
    mode_e      mode1;
    logic       start1, abort1, dut_o1;
    logic       pat_a1, pat_b1, busy1, done1, pass1, ffv1;
    logic [7:0] fc1;
    logic [1:0] ffp1;

    // Instances 2 and 3: WIDTH=2, SETTLE=3, inverted comparator, CNT_W=8 and CNT_W=3
    logic       start2, abort2, dut_o2, dut_o3;
    logic [1:0] pat_a2, pat_b2, pat_a3, pat_b3;
    logic       busy2, done2, pass2, ffv2, busy3, done3, pass3, ffv3;
    logic [7:0] fc2;
    logic [2:0] fc3;
    logic [3:0] ffp2, ffp3;

    function automatic logic cmp_model(input mode_e m, input logic ge);
        case (m)
            M_GOOD:  return ge;
            M_SA1:   return 1'b1;
            M_SA0:   return 1'b0;
            default: return !ge;
        endcase
    endfunction

    always_comb dut_o1 = cmp_model(mode1, pat_a1 >= pat_b1);
    always_comb dut_o2 = !(pat_a2 >= pat_b2);
    always_comb dut_o3 = !(pat_a3 >= pat_b3);

    cmpge_pattern_sequencer #(.WIDTH(1), .SETTLE(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .pat_a(pat_a1), .pat_b(pat_b1), .dut_o(dut_o1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_count(fc1),
        .first_fail_pat(ffp1), .first_fail_valid(ffv1)
    );

    cmpge_pattern_sequencer #(.WIDTH(2), .SETTLE(3), .CNT_W(8)) u2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .pat_a(pat_a2), .pat_b(pat_b2), .dut_o(dut_o2),
        .busy(busy2), .done(done2), .pass(pass2), .fail_count(fc2),
        .first_fail_pat(ffp2), .first_fail_valid(ffv2)
    );

    cmpge_pattern_sequencer #(.WIDTH(2), .SETTLE(3), .CNT_W(3)) u3 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .pat_a(pat_a3), .pat_b(pat_b3), .dut_o(dut_o3),
        .busy(busy3), .done(done3), .pass(pass3), .fail_count(fc3),
        .first_fail_pat(ffp3), .first_fail_valid(ffv3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One sweep on instance 1; abort is also raised during the DONE cycle, which must be ignored.
    task automatic run_vec(input int i, input vec_t v);
        int    busy_cyc, seq_err, late;
        bit    done_seen;
        string t;
        busy_cyc = 0; seq_err = 0; late = 0; done_seen = 0;
        t = $sformatf("v%0d", i);
        @(negedge clk);
        mode1  = v.mode;
        start1 = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start1 = 1'b0;
            abort1 = 1'b0;
            if (done1) begin
                done_seen = 1'b1;
                abort1    = 1'b1;
                break;
            end
            if (!busy1) break;
            busy_cyc++;
            if ({pat_a1, pat_b1} != 2'(k / 2)) seq_err++;
            if (k == v.abort_cyc) abort1 = 1'b1;
        end
        @(negedge clk);
        abort1 = 1'b0;
        check({t, ".busy_cycles"}, busy_cyc, v.exp_busy);
        check({t, ".done_seen"}, done_seen, v.exp_done);
        check({t, ".pattern_seq_errs"}, seq_err, 0);
        check({t, ".busy_done_after"}, {busy1, done1}, 0);
        check({t, ".fail_count"}, fc1, v.exp_fc);
        check({t, ".first_fail_pat"}, ffp1, v.exp_ffp);
        check({t, ".first_fail_valid"}, ffv1, v.exp_ffv);
        check({t, ".pass"}, pass1, v.exp_pass);
        repeat (3) begin
            @(negedge clk);
            if (done1 || busy1) late++;
        end
        check({t, ".quiet_after"}, late, 0);
    endtask

    vec_t vecs[7];

    initial begin
        int  busy_cyc, seq_err, bad;
        bit  found, d2_seen, d3_seen;

        vecs[0] = '{M_GOOD, -1, 8, 1'b1, 0, 2'b00, 1'b0, 1'b1};
        vecs[1] = '{M_SA1,  -1, 8, 1'b1, 1, 2'b01, 1'b1, 1'b0};
        vecs[2] = '{M_SA0,  -1, 8, 1'b1, 3, 2'b00, 1'b1, 1'b0};
        vecs[3] = '{M_SA1,   3, 4, 1'b0, 1, 2'b01, 1'b1, 1'b0};
        vecs[4] = '{M_SA1,  -1, 8, 1'b1, 1, 2'b01, 1'b1, 1'b0};
        vecs[5] = '{M_INV,  -1, 8, 1'b1, 4, 2'b00, 1'b1, 1'b0};
        vecs[6] = '{M_GOOD, -1, 8, 1'b1, 0, 2'b00, 1'b0, 1'b1};

        rst = 1'b1; start1 = 1'b0; abort1 = 1'b0; mode1 = M_GOOD;
        start2 = 1'b0; abort2 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.u1_outputs",
              {pat_a1, pat_b1, busy1, done1, pass1, ffv1, fc1, ffp1}, 0);
        check("reset.u2_outputs",
              {pat_a2, pat_b2, busy2, done2, pass2, ffv2, fc2, ffp2}, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset in the middle of a stuck-at-0 sweep, once pattern 10 is applied.
        @(negedge clk);
        mode1 = M_SA0; start1 = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (busy1 && {pat_a1, pat_b1} == 2'b10) begin
                found = 1'b1;
                break;
            end
        end
        check("rstmid.reached_idx2", found, 1);
        check("rstmid.fc_before", fc1, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid.outputs_zero",
              {pat_a1, pat_b1, busy1, done1, pass1, ffv1, fc1, ffp1}, 0);

        // start together with abort in IDLE must not launch a sweep.
        start1 = 1'b1; abort1 = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy1 || done1 || {pat_a1, pat_b1} != 2'b00) bad++;
        end
        start1 = 1'b0; abort1 = 1'b0;
        @(negedge clk);
        if (busy1 || done1) bad++;
        check("idle.start_with_abort", bad, 0);

        run_vec(7, vecs[0]);

        // WIDTH=2, SETTLE=3, inverted netlist on both wide instances.
        @(negedge clk);
        start2 = 1'b1;
        busy_cyc = 0; seq_err = 0; d2_seen = 0; d3_seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (done3) d3_seen = 1'b1;
            if (done2) begin
                d2_seen = 1'b1;
                break;
            end
            if (!busy2) break;
            busy_cyc++;
            if ({pat_a2, pat_b2} != 4'(k / 4)) seq_err++;
        end
        check("w2.busy_cycles", busy_cyc, 64);
        check("w2.done_seen", d2_seen, 1);
        check("w2.cnt3_done_seen", d3_seen, 1);
        check("w2.pattern_seq_errs", seq_err, 0);
        check("w2.fail_count", fc2, 16);
        check("w2.first_fail_pat", ffp2, 0);
        check("w2.first_fail_valid", ffv2, 1);
        check("w2.pass", pass2, 0);
        check("w2.cnt3_fail_count_sat", fc3, 7);
        check("w2.cnt3_first_fail_pat", ffp3, 0);
        check("w2.cnt3_first_fail_valid", ffv3, 1);
        check("w2.cnt3_pass", pass3, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cmpge_pattern_sequencer.md
Name: cmpge_pattern_sequencer

Overview:
- Sequences exhaustive test patterns onto an unsigned greater-or-equal comparator (cmpge) under test.
- Compares each sampled response against an internally computed golden value, counts mismatches and captures the first failing pattern.
- Sits between the fault-simulation harness (start/done, result readout) and the comparator netlist under test (operand drive, response sample).

Parameters:
- WIDTH, 1, operand width of a and b; pattern space is 2^(2*WIDTH).
- SETTLE, 1, cycles each pattern is held before sampling; legal range 1..15.
- CNT_W, 8, width of fail_count; saturating.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; honoured only in IDLE.
- abort  input  1  cancel a sweep in progress.
- pat_a  output  WIDTH  operand a to the comparator under test.
- pat_b  output  WIDTH  operand b to the comparator under test.
- dut_o  input  1  comparator response; 1 means a >= b.
- busy  output  1  high while a sweep is running.
- done  output  1  one-cycle pulse when a sweep completes normally.
- pass  output  1  last completed sweep had zero mismatches.
- fail_count  output  CNT_W  mismatches in the current or last sweep.
- first_fail_pat  output  2*WIDTH  {a,b} of the first mismatch.
- first_fail_valid  output  1  first_fail_pat holds a captured value.

Behaviour:
- Reset: state=IDLE; pat_a=0, pat_b=0, busy=0, done=0, pass=0, fail_count=0, first_fail_pat=0, first_fail_valid=0. Reset wins over every other input on the same edge.
- Pattern index idx has 2*WIDTH bits, and {pat_a,pat_b}=idx (pat_a is the MSBs). Golden value is exp=(pat_a >= pat_b), unsigned.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE:
  - start=1 and abort=0 at an edge -> APPLY next cycle.
  - On that transition: idx=0, busy=1, fail_count=0, first_fail_valid=0, first_fail_pat=0, pass=0.
  - start and abort high together -> stay IDLE.
- APPLY: holds the pattern for SETTLE cycles using a settle counter, then moves to SAMPLE.
- SAMPLE (1 cycle):
  - dut_o is compared with exp. Any value other than a clean 0/1 (X/Z in simulation) counts as a mismatch.
  - On a mismatch: fail_count increments, saturating at 2^CNT_W-1. If first_fail_valid=0, capture first_fail_pat=idx and set first_fail_valid=1.
  - If idx is all-ones -> DONE. Otherwise idx+1 and return to APPLY; the new pattern appears on pat_a/pat_b the next cycle.
- DONE (1 cycle): done=1, busy=0, pass=(fail_count==0 and no mismatch), then IDLE. pat_a/pat_b hold the last pattern.
- Timing: each pattern takes SETTLE+1 cycles. From the start edge to the done pulse is 2^(2*WIDTH)*(SETTLE+1) cycles of busy, then done.
- abort=1 in APPLY or SAMPLE -> IDLE next cycle.
  - busy=0, done is not pulsed, pass=0.
  - fail_count and first_fail_* keep partial results.
  - A mismatch in the same SAMPLE cycle as abort is still counted.
- start while busy is ignored. abort in IDLE or DONE has no effect; DONE still pulses.
- Reset mid-sweep: all outputs return to reset values on the next edge, and no done pulse is produced.
- Outputs are registered; there is no combinational path from dut_o to any output.

Test Plan:
- WIDTH=1, SETTLE=1, correct cmpge netlist; pulse start -> pat {a,b} sequence 00,01,10,11, each held 2 cycles; busy high 8 cycles; done pulses on cycle 9; pass=1, fail_count=0, first_fail_valid=0.
- Same setup, output stuck-at-1 -> only pattern 01 mismatches (exp=0); fail_count=1, first_fail_pat=2'b01, pass=0.
- Output stuck-at-0 -> patterns 00, 10, 11 mismatch; fail_count=3, first_fail_pat=2'b00, first_fail_valid=1.
- Stuck-at-1 netlist, abort asserted during the pattern-01 SAMPLE cycle -> IDLE next cycle, no done, busy=0, fail_count=1, first_fail_pat=01; a new start clears the results and reruns the full sweep.
- Reset asserted mid-sweep at idx=2 -> next cycle all outputs 0 and state IDLE; start held high together with abort in IDLE -> stays IDLE.
- WIDTH=2, SETTLE=3, inverted comparator -> 16 patterns × 4 cycles = 64 busy cycles; fail_count=16, first_fail_pat=4'b0000; CNT_W=3 variant saturates fail_count at 7.
